// File: rtl/vproc_mem_arbiter_if.sv
// vproc_mem_arbiter_if: native VProc bus between one processor node and the arbiter.
interface vproc_mem_arbiter_if;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        we;
    logic        rd;
    logic        wr_ack;
    logic        rd_ack;
    modport master (output addr, we, rd, data_out, input data_in, wr_ack, rd_ack);
    modport slave  (input addr, we, rd, data_out, output data_in, wr_ack, rd_ack);
endinterface

// File: rtl/vproc_mem_arbiter.sv
// vproc_mem_arbiter: round-robin sharing of one registered memory port between two VProc nodes.
module vproc_mem_arbiter #(
    parameter logic [3:0] SEG    = 4'ha,
    parameter int         MEM_AW = 10,
    parameter int         CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    vproc_mem_arbiter_if.slave  p0,
    vproc_mem_arbiter_if.slave  p1,
    output logic [MEM_AW-1:0]   mem_a,
    output logic [31:0]         mem_di,
    input  logic [31:0]         mem_do,
    output logic                mem_we,
    output logic                mem_cs,
    output logic                busy,
    output logic [CNT_W-1:0]    count0,
    output logic [CNT_W-1:0]    count1
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t      state, state_nxt;
    logic        gnt, gnt_nxt, pri, we_q, rd_q, ack;
    logic        seg0, seg1, req0, req1;
    logic [31:0] rd_data;

    assign seg0 = p0.addr[31:28] == SEG;
    assign seg1 = p1.addr[31:28] == SEG;
    assign req0 = (p0.we | p0.rd) & seg0;
    assign req1 = (p1.we | p1.rd) & seg1;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        case (state)
            IDLE: if (req0 | req1) begin
                state_nxt = BUSY;
                gnt_nxt   = (req0 & req1) ? pri : req1;
            end
            BUSY:    state_nxt = ACK;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            pri     <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            mem_a   <= '0;
            mem_di  <= '0;
            rd_data <= '0;
            count0  <= '0;
            count1  <= '0;
        end else begin
            state <= state_nxt;
            // capture the whole request so later changes on the bus are ignored
            if (state == IDLE && state_nxt == BUSY) begin
                gnt    <= gnt_nxt;
                mem_a  <= gnt_nxt ? p1.addr[MEM_AW-1:0] : p0.addr[MEM_AW-1:0];
                mem_di <= gnt_nxt ? p1.data_out : p0.data_out;
                we_q   <= gnt_nxt ? p1.we : p0.we;
                rd_q   <= gnt_nxt ? p1.rd : p0.rd;
            end
            if (state == BUSY)
                rd_data <= mem_do;
            if (state == ACK) begin
                pri <= ~gnt;
                if (!gnt && count0 != '1)
                    count0 <= count0 + CNT_W'(1);
                if (gnt && count1 != '1)
                    count1 <= count1 + CNT_W'(1);
            end
        end
    end

    assign busy   = state != IDLE;
    assign mem_cs = state == BUSY;
    assign mem_we = mem_cs & we_q;
    assign ack    = state == ACK;

    // out-of-segment accesses are acknowledged combinationally with zero data
    assign p0.wr_ack  = (p0.we & ~seg0) | (ack & ~gnt & we_q);
    assign p0.rd_ack  = (p0.rd & ~seg0) | (ack & ~gnt & rd_q);
    assign p0.data_in = (ack & ~gnt) ? rd_data : '0;
    assign p1.wr_ack  = (p1.we & ~seg1) | (ack & gnt & we_q);
    assign p1.rd_ack  = (p1.rd & ~seg1) | (ack & gnt & rd_q);
    assign p1.data_in = (ack & gnt) ? rd_data : '0;
endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// tb_vproc_mem_arbiter: directed plan scenarios plus random two-port traffic against a memory model.
module tb_vproc_mem_arbiter;
    localparam logic [3:0] SEG = 4'ha;
    logic        clk = 0;
    logic        rst = 1;
    logic [9:0]  mem_a, s_mem_a;
    logic [31:0] mem_di, mem_do, s_mem_di;
    logic        mem_we, mem_cs, busy, s_mem_we, s_mem_cs, s_busy;
    logic [15:0] count0, count1;
    logic [3:0]  s_count0, s_count1;
    logic [31:0] ram [1024] = '{default: 32'h0};
    logic [31:0] ref_mem [1024] = '{default: 32'h0};
    int          errors = 0, checks = 0, mc0 = 0, mc1 = 0, ms0 = 0, we_cycles = 0;
    longint      cyc = 0;
    longint      ack_t [3];

    vproc_mem_arbiter_if b0(), b1(), s0(), s1();

    vproc_mem_arbiter dut (
        .clk(clk), .rst(rst), .p0(b0), .p1(b1),
        .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do), .mem_we(mem_we), .mem_cs(mem_cs),
        .busy(busy), .count0(count0), .count1(count1)
    );

    vproc_mem_arbiter #(.CNT_W(4)) sat (
        .clk(clk), .rst(rst), .p0(s0), .p1(s1),
        .mem_a(s_mem_a), .mem_di(s_mem_di), .mem_do(32'h0), .mem_we(s_mem_we), .mem_cs(s_mem_cs),
        .busy(s_busy), .count0(s_count0), .count1(s_count1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_we) ram[mem_a] <= mem_di;
    always @(negedge clk) if (mem_we) we_cycles <= we_cycles + 1;
    assign mem_do = ram[mem_a];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
        if (p == 0) begin b0.addr = a; b0.we = w; b0.rd = r; b0.data_out = d; end
        else if (p == 1) begin b1.addr = a; b1.we = w; b1.rd = r; b1.data_out = d; end
        else begin s0.addr = a; s0.we = w; s0.rd = r; s0.data_out = d; end
    endtask

    task automatic sample(input int p, output logic wa, output logic ra, output logic [31:0] q);
        if (p == 0) begin wa = b0.wr_ack; ra = b0.rd_ack; q = b0.data_in; end
        else if (p == 1) begin wa = b1.wr_ack; ra = b1.rd_ack; q = b1.data_in; end
        else begin wa = s0.wr_ack; ra = s0.rd_ack; q = s0.data_in; end
    endtask

    // VProc-style access: request held until an ack, then dropped before the next cycle
    task automatic xact(input int p, input logic [31:0] a, input logic w, input logic r, input logic [31:0] d,
                        output int lat, output logic [31:0] q, output logic wa, output logic ra);
        @(negedge clk);
        drive(p, a, w, r, d);
        lat = 0;
        #1 sample(p, wa, ra, q);
        while (!(wa | ra) && lat < 20) begin
            @(negedge clk);
            lat++;
            #1 sample(p, wa, ra, q);
        end
        ack_t[p] = cyc;
        drive(p, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // exp_lat < 0 accepts any latency a fair two-port arbiter can produce (2..5 cycles)
    task automatic op(input int p, input logic [31:0] a, input logic w, input logic r, input logic [31:0] d,
                      input int exp_lat);
        int          lat;
        logic [31:0] q, eq;
        logic        wa, ra, seg;
        seg = a[31:28] == SEG;
        xact(p, a, w, r, d, lat, q, wa, ra);
        eq = (seg && p < 2) ? ref_mem[a[9:0]] : 32'h0;
        check($sformatf("p%0d_data@%h", p, a), q, eq);
        check($sformatf("p%0d_wrack", p), wa, w);
        check($sformatf("p%0d_rdack", p), ra, r);
        if (!seg)
            check($sformatf("p%0d_oos_lat", p), lat, 0);
        else if (exp_lat >= 0)
            check($sformatf("p%0d_lat", p), lat, exp_lat);
        else
            check($sformatf("p%0d_lat_range(%0d)", p, lat), (lat >= 2 && lat <= 5), 1);
        if (seg && p < 2 && w) ref_mem[a[9:0]] = d;
        if (seg) begin
            if (p == 0) mc0 = (mc0 < 65535) ? mc0 + 1 : mc0;
            else if (p == 1) mc1 = (mc1 < 65535) ? mc1 + 1 : mc1;
            else ms0 = (ms0 < 15) ? ms0 + 1 : ms0;
        end
    endtask

    task automatic rand_op(input int p);
        logic [31:0] a;
        logic [1:0]  k;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a = ($urandom_range(0, 4) != 0) ? {SEG, 18'($urandom), 10'($urandom_range(0, 15))}
                                        : {4'($urandom_range(0, 9)), 28'($urandom)};
        k = 2'($urandom_range(1, 3));
        op(p, a, k[1], k[0], $urandom, -1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        mc0 = 0; mc1 = 0; ms0 = 0;
    endtask

    initial begin
        int w0;
        for (int p = 0; p < 3; p++) drive(p, 32'h0, 1'b0, 1'b0, 32'h0);
        s1.addr = 0; s1.we = 0; s1.rd = 0; s1.data_out = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_cs", mem_cs, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_di", mem_di, 0);
        check("rst_count0", count0, 0);
        check("rst_count1", count1, 0);
        check("rst_acks", {b0.wr_ack, b0.rd_ack, b1.wr_ack, b1.rd_ack}, 0);
        rst = 0;

        // single-port write then read back
        w0 = we_cycles;
        op(0, 32'hA000_0010, 1, 0, 32'hDEAD_BEEF, 2);
        check("we_one_cycle", we_cycles - w0, 1);
        op(0, 32'hA000_0010, 0, 1, 32'h0, 2);
        @(negedge clk);
        check("t1_count0", count0, 2);

        // contention after reset: port0 first, then priority rotates
        do_reset();
        fork
            op(0, 32'hA000_0001, 1, 0, 32'h11, 2);
            op(1, 32'hA000_0002, 1, 0, 32'h22, 5);
        join
        op(0, 32'hA000_0001, 0, 1, 32'h0, 2);
        fork
            op(0, 32'hA000_0002, 0, 1, 32'h0, 5);
            op(1, 32'hA000_0001, 0, 1, 32'h0, 2);
        join

        // back-to-back reads from port1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            longint prev;
            prev = ack_t[1];
            op(1, 32'hA000_0001 + i, 0, 1, 32'h0, 2);
            if (i > 0) check("b2b_spacing", 32'(ack_t[1] - prev), 3);
        end
        check("b2b_busy_in_ack", busy, 1);
        @(negedge clk);
        check("b2b_busy_drop", busy, 0);
        check("b2b_count1", count1, 4);

        // out-of-segment write alongside an in-segment read
        fork
            op(1, 32'hA000_0002, 0, 1, 32'h0, 2);
            op(0, 32'h5000_0000, 1, 0, 32'h5555_AAAA, 0);
        join
        @(negedge clk);
        check("oos_count0", count0, mc0);
        check("oos_count1", count1, mc1);

        // reset in the middle of a write access
        op(0, 32'hA000_0020, 1, 0, 32'hCAFE_0001, 2);
        @(negedge clk) drive(0, 32'hA000_0020, 1'b1, 1'b0, 32'h1234_5678);
        @(negedge clk);
        check("mid_busy_we", mem_we, 1);
        #1 rst = 1;
        #1;
        check("mid_we_drop", mem_we, 0);
        check("mid_busy_drop", busy, 0);
        check("mid_no_ack", b0.wr_ack, 0);
        check("mid_count0", count0, 0);
        drive(0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk) rst = 0;
        mc0 = 0; mc1 = 0; ms0 = 0;
        op(0, 32'hA000_0020, 0, 1, 32'h0, 2);

        // saturation on the narrow-counter instance
        for (int i = 0; i < 17; i++) begin
            op(2, 32'hA000_0003, 1, 0, 32'(i), 2);
            if (i == 14) begin
                @(negedge clk);
                check("sat_at_15", s_count0, 15);
            end
        end
        @(negedge clk);
        check("sat_sticks", s_count0, 4'hF);
        check("sat_model", s_count0, ms0);

        // random concurrent traffic
        do_reset();
        fork
            for (int i = 0; i < 30; i++) rand_op(0);
            for (int j = 0; j < 30; j++) rand_op(1);
        join
        @(negedge clk);
        check("rand_count0", count0, mc0);
        check("rand_count1", count1, mc1);
        check("rand_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vproc_mem_arbiter.md
Name: vproc_mem_arbiter

Overview:
Two-port round-robin arbiter that shares the single 1K-word memory model between VProc node 0 and node 1. Each port presents the native VProc bus: Addr, WE, RD and DataOut from the processor; DataIn, WRAck and RDAck back to it. The arbiter decodes the memory segment, serialises accesses onto one registered memory interface and returns single-cycle acks. Per-port transaction counters support bench statistics.

Parameters:
SEG, 4'ha, value of Addr[31:28] that selects memory.
MEM_AW, 10, memory word-address width; MemA = Addr[MEM_AW-1:0].
CNT_W, 16, width of the per-port saturating transaction counters.

Ports:
Clk  input  1  system clock, all state on posedge
Reset  input  1  asynchronous, active-high reset
Addr0/Addr1  input  32  VProc address, per port
WE0/WE1  input  1  write request, held until WRAck
RD0/RD1  input  1  read request, held until RDAck
DataOut0/DataOut1  input  32  write data from VProc
DataIn0/DataIn1  output  32  read data to VProc
WRAck0/WRAck1  output  1  write acknowledge
RDAck0/RDAck1  output  1  read acknowledge
MemA  output  MEM_AW  memory word address
MemDI  output  32  memory write data
MemDO  input  32  memory read data, combinational from MemA
MemWE  output  1  memory write enable
MemCS  output  1  memory chip select
Busy  output  1  high in any state other than IDLE
Count0/Count1  output  CNT_W  completed in-segment transactions per port

Behaviour:
- Port n request valid (ReqN) = (WEn|RDn) & (Addrn[31:28]==SEG).
- Out-of-segment access, (WEn|RDn) with Addrn[31:28]!=SEG:
  - WRAckn=WEn and RDAckn=RDn, combinationally in the same cycle.
  - DataInn=0. No arbitration, no counter change, no memory activity.
- FSM states: IDLE, BUSY, ACK. Registers: Gnt (0/1), Pri (port with priority), RdData[31:0].
- IDLE:
  - Neither ReqN set: stay in IDLE.
  - One ReqN set: Gnt=that port, go to BUSY.
  - Both set: Gnt=Pri, go to BUSY.
- BUSY (exactly one cycle):
  - MemCS=1. MemA, MemDI and MemWE (=WE of the granted port) are driven from registers loaded on the IDLE->BUSY edge.
  - RdData<=MemDO on the exit edge.
  - Go to ACK.
- ACK (exactly one cycle):
  - Granted port sees WRAck=1 if its WE was captured, RDAck=1 if its RD was captured.
  - DataIn of the granted port = RdData. DataIn of the non-granted port = 0.
  - On exit: Pri<=~Gnt, Count[Gnt]++ (saturates at all-ones), go to IDLE.
- Latency: request seen in cycle c; memory access in c+1; ack in c+2. Throughput is 1 access per 3 cycles. A new request from the same port is accepted in IDLE at c+3.
- WE and RD both captured for one port: treated as write. Memory is written, and WRAck and RDAck both pulse in ACK.
- Request changes after capture: ignored. Captured address, data and type are used.
- MemWE=0 and MemCS=0 outside BUSY. In-segment acks are 0 outside ACK.
- Reset (async, any state, including mid-BUSY):
  - State=IDLE; Gnt=0; Pri=0.
  - All acks, MemWE and MemCS are 0.
  - MemA=0, MemDI=0, RdData=0; Count0=Count1=0.
  - A write in BUSY is aborted, because MemWE falls immediately.
- After reset release, first contention goes to port 0.

Test Plan:
- Port0 write 0xDEADBEEF to 0xA0000010, then read the same address -> MemWE high in cycle c+1 only; WRAck0 pulses at c+2; read RDAck0 pulses with DataIn0=0xDEADBEEF; Count0=2.
- Port0 and port1 write simultaneously after reset (0xA0000001 data 0x11, 0xA0000002 data 0x22) -> port0 acked at c+2, port1 acked at c+5; next contention grants port1 first.
- Port1 issues 4 back-to-back reads with port0 idle -> RDAck1 pulses every 3 cycles; Count1=4; Busy drops 1 cycle after the last ack.
- Port0 write to 0x50000000 while port1 holds an in-segment read -> WRAck0 high in the same cycle; port1 read completes unaffected; Count0 unchanged.
- Assert Reset during BUSY of a write of 0x12345678 to 0xA0000020 -> MemWE drops asynchronously; no ack; a subsequent read returns the prior contents; counters are 0.
- CNT_W=4, port0 issues 17 transactions -> Count0 sticks at 4'hF.
